// File: rtl/add_acc_pkg.sv
// rtl/add_acc_pkg.sv - shared FSM state type and beat-counter sizing for the add-result accumulator
package add_acc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int N_OPS_DEFAULT = 8;

  // Counter runs 0..n-1, so clog2(n) bits with a floor of one bit for n=1.
  function automatic int beat_cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  localparam int BEAT_CNT_W = beat_cnt_width(N_OPS_DEFAULT);

endpackage

// File: rtl/add_result_accumulator_if.sv
// rtl/add_result_accumulator_if.sv - adder-result input stream and batch-result output bundle
interface add_result_accumulator_if #(
  parameter int W  = 16,
  parameter int AW = 18
);
  logic          start;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  sum;
  logic          c_out;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] acc;
  logic [7:0]    carry_cnt;
  logic          ovf;

  modport master (
    output start, in_valid, sum, c_out, out_ready,
    input  in_ready, out_valid, acc, carry_cnt, ovf
  );

  modport slave (
    input  start, in_valid, sum, c_out, out_ready,
    output in_ready, out_valid, acc, carry_cnt, ovf
  );
endinterface

// File: rtl/acc_sat_add.sv
// rtl/acc_sat_add.sv - AW-bit accumulate step with overflow flag
// ACC_SATURATE_EN defined: clamp at all-ones on overflow; undefined: wrap modulo 2^AW.
module acc_sat_add #(
  parameter int W  = 16,
  parameter int AW = 18
) (
  input  logic [AW-1:0] acc_i,
  input  logic [W:0]    addend_i,
  output logic [AW-1:0] sum_o,
  output logic          ovf_o
);
  logic [AW:0] full;

  assign full  = {1'b0, acc_i} + {{(AW-W){1'b0}}, addend_i};
  assign ovf_o = full[AW];

`ifdef ACC_SATURATE_EN
  // Once clamped, any further non-zero add overflows again, so the value sticks.
  assign sum_o = ovf_o ? {AW{1'b1}} : full[AW-1:0];
`else
  assign sum_o = full[AW-1:0];
`endif

endmodule

// File: rtl/add_result_accumulator.sv
// rtl/add_result_accumulator.sv - batches N_OPS adder results {c_out,sum} into one total
// Overflow policy selected by ACC_SATURATE_EN inside acc_sat_add.
module add_result_accumulator
  import add_acc_pkg::*;
#(
  parameter int W     = 16,
  parameter int AW    = 18,
  parameter int N_OPS = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  add_result_accumulator_if.slave   bus
);
  localparam int CW = beat_cnt_width(N_OPS);
  localparam logic [CW-1:0] LAST_BEAT = CW'(N_OPS - 1);

  state_e        state_q, state_d;
  logic [AW-1:0] acc_q, acc_d;
  logic [7:0]    carry_q, carry_d;
  logic          ovf_q, ovf_d;
  logic [CW-1:0] beat_q, beat_d;
  logic [AW-1:0] add_sum;
  logic          add_ovf;
  logic          fire;

  acc_sat_add #(.W(W), .AW(AW)) u_add (
    .acc_i    (acc_q),
    .addend_i ({bus.c_out, bus.sum}),
    .sum_o    (add_sum),
    .ovf_o    (add_ovf)
  );

  assign fire          = bus.in_valid && (state_q == ACCUM);
  assign bus.in_ready  = (state_q == ACCUM);
  assign bus.out_valid = (state_q == DONE);
  assign bus.acc       = acc_q;
  assign bus.carry_cnt = carry_q;
  assign bus.ovf       = ovf_q;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    beat_d  = beat_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = ACCUM;
          acc_d   = '0;
          carry_d = '0;
          ovf_d   = 1'b0;
          beat_d  = '0;
        end
      end
      ACCUM: begin
        if (fire) begin
          acc_d   = add_sum;
          ovf_d   = ovf_q | add_ovf;
          carry_d = carry_q + {7'd0, bus.c_out};
          if (beat_q == LAST_BEAT) begin
            beat_d  = '0;
            state_d = DONE;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      carry_q <= '0;
      ovf_q   <= 1'b0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      beat_q  <= beat_d;
    end
  end

endmodule
